// File: rtl/qmult_arbiter.sv
// qmult_arbiter
//   Four-requester round-robin front end for a single Q9.22 fixed-point
//   multiplier. One operation is in flight at a time. The FSM moves
//   IDLE -> CALC -> RESP. A request is accepted in IDLE. The signed product
//   is formed and registered in CALC. The result is held in RESP until the
//   downstream side takes it.
//
// Ports
//   clk        : single clock, all state on rising edge
//   rst        : synchronous active-high reset
//   req_valid  : per-requester request valid (bit i = requester i)
//   req_ready  : per-requester accept, one-hot or zero, only in IDLE
//   req_a      : multiplicands, requester i on [N*i +: N]
//   req_b      : multipliers,   requester i on [N*i +: N]
//   rsp_valid  : result valid (high only in RESP)
//   rsp_ready  : downstream accepts the result
//   rsp_id     : index of the requester owning the result
//   rsp_data   : Q9.22 product, truncated toward negative infinity, wraps
//   rsp_ovr    : product did not fit in N bits
//   busy       : high whenever the FSM is not in IDLE

module qmult_arbiter #(
    parameter int NREQ = 4,
    parameter int N    = 32,
    parameter int Q    = 22
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*N-1:0]         req_a,
    input  logic [NREQ*N-1:0]         req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [N-1:0]              rsp_data,
    output logic                      rsp_ovr,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   lastGrant_q, lastGrant_d;
    logic [IW-1:0]   rspId_q, rspId_d;
    logic [N-1:0]    opA_q, opA_d;
    logic [N-1:0]    opB_q, opB_d;
    logic [N-1:0]    rspData_q, rspData_d;
    logic            rspOvr_q, rspOvr_d;

    logic [IW-1:0]   grantIdx;
    logic            grantValid;
    logic            accept;
    logic [N-1:0]    sliceA [NREQ];
    logic [N-1:0]    sliceB [NREQ];
    logic [2*N-1:0]  product;
    logic            unusedProductBits;

    // Unpack the flat operand buses so the granted slice can be picked by index.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            sliceA[i] = req_a[i*N +: N];
            sliceB[i] = req_b[i*N +: N];
        end
    end

    // Round-robin search starting just after the last grant. Scanning from
    // the farthest candidate down to the nearest lets the nearest set bit win.
    // The index wraps by plain IW-bit overflow, so NREQ must be a power of two.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = lastGrant_q;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[lastGrant_q + IW'(k)]) begin
                grantValid = 1'b1;
                grantIdx   = lastGrant_q + IW'(k);
            end
        end
    end

    // Ready is offered only to the chosen requester, only in IDLE, and never
    // while reset is asserted.
    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && !rst && grantValid) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    // Sign-extend both operands to 2N bits. The low 2N bits of the unsigned
    // product are then the exact signed product.
    assign product = {{N{opA_q[N-1]}}, opA_q} * {{N{opB_q[N-1]}}, opB_q};

    // The truncated fraction and the middle sign bits do not reach any output.
    assign unusedProductBits = ^{product[Q-1:0], product[2*N-2:N+Q]};

    // Next-state and datapath capture. Overflow means the bits above the kept
    // window are not all copies of the result sign bit. Only the top bit is
    // compared against the result sign.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        rspId_d     = rspId_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        rspData_d   = rspData_q;
        rspOvr_d    = rspOvr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = CALC;
                    lastGrant_d = grantIdx;
                    rspId_d     = grantIdx;
                    opA_d       = sliceA[grantIdx];
                    opB_d       = sliceB[grantIdx];
                end
            end
            CALC: begin
                rspData_d = product[N+Q-1:Q];
                rspOvr_d  = product[2*N-1] ^ product[N+Q-1];
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset parks last_grant at the top index so requester 0 is first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= IW'(NREQ - 1);
            rspId_q     <= '0;
            opA_q       <= '0;
            opB_q       <= '0;
            rspData_q   <= '0;
            rspOvr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            rspId_q     <= rspId_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            rspData_q   <= rspData_d;
            rspOvr_q    <= rspOvr_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rspId_q;
    assign rsp_data  = rspData_q;
    assign rsp_ovr   = rspOvr_q;

endmodule

// File: tb/tb_qmult_arbiter.sv
// tb_qmult_arbiter
//   Self-checking bench for qmult_arbiter. Table vectors drive one requester
//   at a time. Hand-written sequences cover fairness, backpressure and reset
//   in flight. A negedge monitor pushes the expected result for each observed
//   accept into a scoreboard queue. It pops and compares that entry when the
//   response handshake occurs.

module tb_qmult_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 32;
    localparam int Q    = 22;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [N-1:0]      rsp_data;
    logic              rsp_ovr;
    logic              busy;

    qmult_arbiter #(.NREQ(NREQ), .N(N), .Q(Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ovr   (rsp_ovr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expData;
        logic        expOvr;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        ovr;
        int          acceptCycle;
    } exp_t;

    exp_t        sbQ[$];
    int          grantLog[$];
    int          acceptLog[$];
    logic [31:0] pendData [NREQ];
    logic        pendOvr  [NREQ];
    vec_t        vecs [8];

    int   checkCount = 0;
    int   passCount  = 0;
    int   cycle      = 0;
    int   multiHot   = 0;
    int   monG;
    int   gotId;
    logic rspValidPrev = 1'b0;
    exp_t popped;

    // Every comparison goes through here so the counts stay consistent.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference Q9.22 multiply: full signed product, keep [53:22], flag when
    // the top bit disagrees with the kept sign bit.
    function automatic void qmulModel(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] data, output logic ovr);
        logic [63:0] p;
        p    = 64'(longint'($signed(a)) * longint'($signed(b)));
        data = p[53:22];
        ovr  = p[63] ^ p[53];
    endfunction

    // Load a requester's operands and the result expected for them.
    task automatic setRequester(input int id, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expData, input logic expOvr);
        req_a[id*N +: N] = a;
        req_b[id*N +: N] = b;
        pendData[id]     = expData;
        pendOvr[id]      = expOvr;
    endtask

    // Wait (bounded) for any request handshake and report the granted index.
    task automatic waitAccept(input string name, output int granted);
        bit seen;
        seen    = 1'b0;
        granted = -1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                seen = 1'b1;
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (req_valid[i] && req_ready[i]) granted = i;
                end
            end
        end
        if (!seen) checkOutput({name, "_accept_timeout"}, 64'd0, 64'd1);
    endtask

    // Wait (bounded) until the scoreboard is empty and the DUT is idle again.
    task automatic waitDrain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) checkOutput({name, "_drain_timeout"}, 64'd0, 64'd1);
    endtask

    // Drive one table vector from a single requester and let it complete.
    task automatic applyStimulus(input vec_t v, input string name);
        int g;
        @(posedge clk); #1;
        setRequester(v.id, v.a, v.b, v.expData, v.expOvr);
        req_valid = 4'b0001 << v.id;
        waitAccept(name, g);
        checkOutput({name, "_grant"}, 64'(g), 64'(v.id));
        @(posedge clk); #1;
        req_valid = '0;
        waitDrain(name);
    endtask

    // Scoreboard monitor: push on accept, check latency on rsp_valid rising,
    // pop and compare on response handshake. Reset flushes anything in flight.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (rst) begin
                sbQ.delete();
            end else begin
                if ($countones(req_ready) > 1) multiHot++;
                if (|(req_valid & req_ready)) begin
                    monG = 0;
                    for (int i = NREQ - 1; i >= 0; i--) begin
                        if (req_valid[i] && req_ready[i]) monG = i;
                    end
                    sbQ.push_back('{id: 2'(monG), data: pendData[monG], ovr: pendOvr[monG], acceptCycle: cycle});
                    grantLog.push_back(monG);
                    acceptLog.push_back(cycle);
                end
                if (rsp_valid && !rspValidPrev) begin
                    if (sbQ.size() == 0) checkOutput("rsp_unexpected", 64'd1, 64'd0);
                    else checkOutput("latency", 64'(cycle - sbQ[0].acceptCycle), 64'd2);
                end
                if (rsp_valid && rsp_ready && sbQ.size() > 0) begin
                    popped = sbQ.pop_front();
                    checkOutput("rsp_id", 64'(rsp_id), 64'(popped.id));
                    checkOutput("rsp_data", 64'(rsp_data), 64'(popped.data));
                    checkOutput("rsp_ovr", 64'(rsp_ovr), 64'(popped.ovr));
                end
            end
            rspValidPrev = rsp_valid;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int          expOrder [6];
    logic [31:0] d;
    logic        o;

    initial begin
        vecs[0] = '{id: 0, a: 32'h0060_0000, b: 32'h0080_0000, expData: 32'h00C0_0000, expOvr: 1'b0};
        vecs[1] = '{id: 2, a: 32'hFFC0_0000, b: 32'h0060_0000, expData: 32'hFFA0_0000, expOvr: 1'b0};
        vecs[2] = '{id: 1, a: 32'h4000_0000, b: 32'h0080_0000, expData: 32'h8000_0000, expOvr: 1'b1};
        vecs[3] = '{id: 3, a: 32'h0000_0001, b: 32'h0020_0000, expData: 32'h0000_0000, expOvr: 1'b0};
        vecs[4] = '{id: 3, a: 32'hFFFF_FFFF, b: 32'h0020_0000, expData: 32'hFFFF_FFFF, expOvr: 1'b0};
        vecs[5] = '{id: 0, a: 32'hC000_0000, b: 32'h0080_0000, expData: 32'h8000_0000, expOvr: 1'b0};
        vecs[6] = '{id: 2, a: 32'h0040_0000, b: 32'h7FFF_FFFF, expData: 32'h7FFF_FFFF, expOvr: 1'b0};
        vecs[7] = '{id: 1, a: 32'h0100_0000, b: 32'h0100_0000, expData: 32'h0400_0000, expOvr: 1'b0};
        expOrder = '{0, 1, 2, 3, 0, 1};

        // Reset with every requester asserting: nothing may be accepted.
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            pendData[i] = '0;
            pendOvr[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("reset_rsp_ovr", 64'(rsp_ovr), 64'd0);

        // Table-driven single-requester vectors.
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v], $sformatf("vec%0d", v));
        end

        // Fairness: all requesters held high from reset.
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            qmulModel(32'((i + 1) << 22), 32'h0080_0000, d, o);
            setRequester(i, 32'((i + 1) << 22), 32'h0080_0000, d, o);
        end
        grantLog.delete();
        acceptLog.delete();
        @(negedge clk);
        checkOutput("fair_reset_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (grantLog.size() >= 6) break;
        end
        req_valid = '0;
        checkOutput("fair_accepts", 64'(grantLog.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < grantLog.size()) checkOutput($sformatf("fair_grant%0d", k), 64'(grantLog[k]), 64'(expOrder[k]));
        end
        for (int k = 1; k < 6; k++) begin
            if (k < acceptLog.size()) checkOutput($sformatf("fair_spacing%0d", k), 64'(acceptLog[k] - acceptLog[k-1]), 64'd3);
        end
        waitDrain("fair");

        // Backpressure: hold rsp_ready low for 5 RESP cycles while requester 1 waits.
        setRequester(3, 32'h0060_0000, 32'h0080_0000, 32'h00C0_0000, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        waitAccept("bp", gotId);
        checkOutput("bp_grant", 64'(gotId), 64'd3);
        @(posedge clk); #1;
        qmulModel(32'h0040_0000, 32'hFFE0_0000, d, o);
        setRequester(1, 32'h0040_0000, 32'hFFE0_0000, d, o);
        req_valid = 4'b0010;
        @(negedge clk);
        checkOutput("bp_calc_req_ready", 64'(req_ready), 64'd0);
        checkOutput("bp_calc_rsp_valid", 64'(rsp_valid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d_valid", k), 64'(rsp_valid), 64'd1);
            checkOutput($sformatf("bp_hold%0d_data", k), 64'(rsp_data), 64'h00C0_0000);
            checkOutput($sformatf("bp_hold%0d_id", k), 64'(rsp_id), 64'd3);
            checkOutput($sformatf("bp_hold%0d_ovr", k), 64'(rsp_ovr), 64'd0);
            checkOutput($sformatf("bp_hold%0d_req_ready", k), 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        checkOutput("bp_idle_busy", 64'(busy), 64'd0);
        checkOutput("bp_idle_req_ready", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        waitDrain("bp");

        // Reset pulsed during CALC: the operation vanishes, priority restarts at 0.
        setRequester(2, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 1'b0);
        @(posedge clk); #1;
        req_valid = 4'b0100;
        waitAccept("rif", gotId);
        @(posedge clk); #1;
        req_valid = '0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rif_no_rsp%0d", k), 64'(rsp_valid), 64'd0);
        end
        checkOutput("rif_busy", 64'(busy), 64'd0);
        qmulModel(32'h0080_0000, 32'h0060_0000, d, o);
        setRequester(0, 32'h0080_0000, 32'h0060_0000, d, o);
        qmulModel(32'hFF80_0000, 32'h0060_0000, d, o);
        setRequester(1, 32'hFF80_0000, 32'h0060_0000, d, o);
        @(posedge clk); #1;
        req_valid = 4'b0011;
        waitAccept("rif2", gotId);
        checkOutput("rif_grant", 64'(gotId), 64'd0);
        @(posedge clk); #1;
        req_valid = '0;
        waitDrain("rif2");

        checkOutput("multi_hot_ready", 64'(multiHot), 64'd0);
        checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/qmult_arbiter.md
QMULT_ARBITER -- requirements
Module: qmult_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; fixed at 4.
REQ-002 Parameter N, default 32: operand and result width in bits, signed two's complement.
REQ-003 Parameter Q, default 22: fractional bits of the Q9.22 fixed-point format.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  4  per-requester request valid; bit i belongs to requester i.
REQ-007 req_ready  output  4  per-requester accept; at most one bit high in any cycle.
REQ-008 req_a  input  128  multiplicands; requester i on bits [32i+31:32i].
REQ-009 req_b  input  128  multipliers; requester i on bits [32i+31:32i].
REQ-010 rsp_valid  output  1  result valid.
REQ-011 rsp_ready  input  1  downstream accepts the result.
REQ-012 rsp_id  output  2  index of the requester that owns the result.
REQ-013 rsp_data  output  32  Q9.22 product.
REQ-014 rsp_ovr  output  1  overflow flag for rsp_data.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states are IDLE, CALC and RESP; there are no other states.
REQ-017 IDLE: if any req_valid is high, the grant goes to the first set bit searched from (last_grant+1) mod 4 upward with wrap-around.
REQ-018 IDLE: req_ready[g] is combinationally high for the granted g only; all req_ready bits are low in CALC and RESP.
REQ-019 A handshake (req_valid[g] and req_ready[g]) captures req_a/req_b slice g and id g, sets last_grant to g, and moves the FSM to CALC.
REQ-020 CALC: one cycle. It forms the full 64-bit signed product of the captured operands and registers rsp_data = product[53:22] and rsp_ovr = (product[63] != product[53]), then moves to RESP.
REQ-021 Fractional bits below product[22] are truncated, which rounds toward negative infinity; there is no saturation, and an overflowed result wraps.
REQ-022 RESP: rsp_valid is high. rsp_id, rsp_data and rsp_ovr are held stable until rsp_valid and rsp_ready are both high, then the FSM moves to IDLE.
REQ-023 Latency: a handshake in cycle T gives rsp_valid high in cycle T+2.
REQ-024 Throughput: with rsp_ready held high, one accept every 3 cycles at most.
REQ-025 Only one operation is outstanding at a time; rsp_valid is never high in IDLE or CALC.
REQ-026 A requester that drops req_valid while not granted loses nothing; it has no accepted state.
REQ-027 Operand slices of requesters that are not granted are ignored.
REQ-028 If rsp_ready is high in the same cycle RESP is entered, the result completes that cycle; the next accept is one cycle later, in IDLE.

Reset
REQ-029 With rst high at a clock edge, the FSM goes to IDLE and last_grant goes to 3, so requester 0 has first priority.
REQ-030 With rst high at a clock edge, rsp_valid, rsp_data, rsp_id, rsp_ovr and busy all go to 0.
REQ-031 req_ready is all 0 during any cycle in which rst is high.
REQ-032 A reset asserted in CALC or RESP discards the operation in flight; no response is ever produced for it.

Verification
REQ-033 Basic: requester 0 sends a=0x00600000 (1.5), b=0x00800000 (2.0) -> rsp_data=0x00C00000, rsp_ovr=0, rsp_id=0, exactly 2 cycles after accept.
REQ-034 Sign: requester 2 sends a=0xFFC00000 (-1.0), b=0x00600000 -> rsp_data=0xFFA00000, rsp_ovr=0, rsp_id=2.
REQ-035 Overflow: a=0x40000000 (256.0), b=0x00800000 (2.0) -> rsp_data=0x80000000, rsp_ovr=1.
REQ-036 Fairness: all 4 req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0,1, one accept every 3 cycles, and req_ready is never multi-hot.
REQ-037 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid and payload stay stable and req_ready stays 0; on release, completion occurs, then IDLE is entered.
REQ-038 Reset in flight: rst pulsed in the CALC cycle -> no rsp_valid afterwards, busy=0, and the next simultaneous request from requesters 1 and 0 grants requester 0.
